// File: rtl/hs_mon_pkg.sv
// Shared types and helpers for the ready/valid protocol monitor.
package hs_mon_pkg;

    typedef enum logic [1:0] {
        NONE        = 2'd0,
        VALID_DROP  = 2'd1,
        DATA_CHANGE = 2'd2,
        TIMEOUT     = 2'd3
    } err_code_t;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } ch_state_t;

    // Increment that sticks at max_v; callers cast to their own width.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/hs_channel_checker.sv
// One monitored ready/valid channel: IDLE/PEND FSM, hold register, stall and transfer counters.
// Sticky flags are registered (1-cycle latency); ev_* are same-cycle events used for first-error capture.
module hs_channel_checker
    import hs_mon_pkg::*;
#(
    parameter int DATA_W      = 5,
    parameter int CNT_W       = 16,
    parameter int STALL_LIMIT = 64
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clear_i,
    input  logic              valid_i,
    input  logic              ready_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [CNT_W-1:0]  xfer_count_o,
    output logic              ev_valid_drop_o,
    output logic              ev_data_change_o,
    output logic              ev_timeout_o,
    output logic              err_valid_drop_o,
    output logic              err_data_change_o,
    output logic              err_timeout_o
);
    localparam int          ST_W      = $clog2(STALL_LIMIT + 1);
    localparam logic [31:0] CNT_MAX   = 32'((64'd1 << CNT_W) - 64'd1);
    localparam logic [31:0] STALL_MAX = 32'(STALL_LIMIT);

    ch_state_t         state_q;
    logic [DATA_W-1:0] hold_q;
    logic [ST_W-1:0]   stall_q;
    logic [ST_W-1:0]   stall_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              vd_q, dc_q, to_q;
    logic              live, stalled, accepted;

    assign live     = rst_n_i & ~clear_i;
    assign stalled  = valid_i & ~ready_i;
    assign accepted = valid_i & ready_i;
    assign cnt_d    = CNT_W'(sat_inc(32'(cnt_q), CNT_MAX));
    assign stall_d  = ST_W'(sat_inc(32'(stall_q), STALL_MAX));

    // Timeout fires only on the step into STALL_LIMIT, so once per episode.
    always_comb begin
        ev_valid_drop_o  = live && (state_q == PEND) && !valid_i;
        ev_data_change_o = live && (state_q == PEND) && valid_i && (data_i != hold_q);
        if (state_q == IDLE)
            ev_timeout_o = live && stalled && (STALL_LIMIT == 1);
        else
            ev_timeout_o = live && stalled && (32'(stall_q) == STALL_MAX - 32'd1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || clear_i) begin
            state_q <= IDLE;
            hold_q  <= '0;
            stall_q <= '0;
            cnt_q   <= '0;
            vd_q    <= 1'b0;
            dc_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            if (accepted)
                cnt_q <= cnt_d;
            case (state_q)
                IDLE: if (stalled) begin
                    state_q <= PEND;
                    hold_q  <= data_i;
                    stall_q <= ST_W'(1);
                end
                PEND: if (!valid_i || ready_i)
                    state_q <= IDLE;
                else
                    stall_q <= stall_d;
                default: state_q <= IDLE;
            endcase
            vd_q <= vd_q | ev_valid_drop_o;
            dc_q <= dc_q | ev_data_change_o;
            to_q <= to_q | ev_timeout_o;
        end
    end

    assign xfer_count_o      = cnt_q;
    assign err_valid_drop_o  = vd_q;
    assign err_data_change_o = dc_q;
    assign err_timeout_o     = to_q;

endmodule

// File: rtl/hs_protocol_monitor.sv
// Passive N-channel ready/valid monitor: per-channel checkers plus first-error capture.
// Errors register one cycle after the offending sample; never drives or backpressures the channels.
module hs_protocol_monitor
    import hs_mon_pkg::*;
#(
    parameter int N_CH        = 3,
    parameter int DATA_W      = 5,
    parameter int CNT_W       = 16,
    parameter int STALL_LIMIT = 64,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   CLK,
    input  logic                   RESETN,
    input  logic                   clear,
    input  logic [N_CH-1:0]        valid,
    input  logic [N_CH-1:0]        ready,
    input  logic [N_CH*DATA_W-1:0] data,
    output logic [N_CH*CNT_W-1:0]  xfer_count,
    output logic [N_CH-1:0]        err_valid_drop,
    output logic [N_CH-1:0]        err_data_change,
    output logic [N_CH-1:0]        err_timeout,
    output logic                   err_any,
    output logic                   first_err_valid,
    output logic [CH_W-1:0]        first_err_chan,
    output logic [1:0]             first_err_code
);
    logic [N_CH-1:0] ev_vd, ev_dc, ev_to;
    logic            hit_d;
    logic [CH_W-1:0] chan_d;
    err_code_t       code_d;
    logic            fv_q;
    logic [CH_W-1:0] chan_q;
    err_code_t       code_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        hs_channel_checker #(
            .DATA_W      (DATA_W),
            .CNT_W       (CNT_W),
            .STALL_LIMIT (STALL_LIMIT)
        ) u_chk (
            .clk_i             (CLK),
            .rst_n_i           (RESETN),
            .clear_i           (clear),
            .valid_i           (valid[i]),
            .ready_i           (ready[i]),
            .data_i            (data[i*DATA_W +: DATA_W]),
            .xfer_count_o      (xfer_count[i*CNT_W +: CNT_W]),
            .ev_valid_drop_o   (ev_vd[i]),
            .ev_data_change_o  (ev_dc[i]),
            .ev_timeout_o      (ev_to[i]),
            .err_valid_drop_o  (err_valid_drop[i]),
            .err_data_change_o (err_data_change[i]),
            .err_timeout_o     (err_timeout[i])
        );
    end

    // Scan high to low so the lowest channel index is the last writer and wins.
    always_comb begin
        hit_d  = 1'b0;
        chan_d = '0;
        code_d = NONE;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ev_vd[i] | ev_dc[i] | ev_to[i]) begin
                hit_d  = 1'b1;
                chan_d = CH_W'(i);
                code_d = ev_vd[i] ? VALID_DROP : (ev_dc[i] ? DATA_CHANGE : TIMEOUT);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN || clear) begin
            fv_q   <= 1'b0;
            chan_q <= '0;
            code_q <= NONE;
        end else if (!fv_q && hit_d) begin
            fv_q   <= 1'b1;
            chan_q <= chan_d;
            code_q <= code_d;
        end
    end

    assign err_any         = |{err_valid_drop, err_data_change, err_timeout};
    assign first_err_valid = fv_q;
    assign first_err_chan  = chan_q;
    assign first_err_code  = code_q;

endmodule

// File: tb/tb_hs_protocol_monitor.sv
// Scoreboarded bench for hs_protocol_monitor (N_CH=3, DATA_W=5, CNT_W=4, STALL_LIMIT=4).
module tb_hs_protocol_monitor;
    localparam int N_CH        = 3;
    localparam int DATA_W      = 5;
    localparam int CNT_W       = 4;
    localparam int STALL_LIMIT = 4;
    localparam int CH_W        = 2;
    localparam int CNT_SAT     = 15;

    logic                   CLK = 1'b0;
    logic                   RESETN, clear;
    logic [N_CH-1:0]        valid, ready;
    logic [N_CH*DATA_W-1:0] data;
    logic [N_CH*CNT_W-1:0]  xfer_count;
    logic [N_CH-1:0]        err_valid_drop, err_data_change, err_timeout;
    logic                   err_any, first_err_valid;
    logic [CH_W-1:0]        first_err_chan;
    logic [1:0]             first_err_code;

    hs_protocol_monitor #(
        .N_CH(N_CH), .DATA_W(DATA_W), .CNT_W(CNT_W), .STALL_LIMIT(STALL_LIMIT)
    ) dut (
        .CLK(CLK), .RESETN(RESETN), .clear(clear), .valid(valid), .ready(ready), .data(data),
        .xfer_count(xfer_count), .err_valid_drop(err_valid_drop),
        .err_data_change(err_data_change), .err_timeout(err_timeout), .err_any(err_any),
        .first_err_valid(first_err_valid), .first_err_chan(first_err_chan),
        .first_err_code(first_err_code)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [N_CH*CNT_W-1:0] cnt;
        logic [N_CH-1:0]       vd, dc, to;
        logic                  any, fv;
        logic [CH_W-1:0]       fch;
        logic [1:0]            fcode;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state
    logic            m_pend [N_CH];
    logic [DATA_W-1:0] m_hold [N_CH];
    int              m_stall [N_CH];
    int              m_cnt [N_CH];
    logic [N_CH-1:0] m_vd, m_dc, m_to;
    logic            m_fv;
    logic [CH_W-1:0] m_fch;
    logic [1:0]      m_fcode;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N_CH*DATA_W-1:0] pk(input logic [DATA_W-1:0] d0, d1, d2);
        return {d2, d1, d0};
    endfunction

    function automatic logic [CNT_W-1:0] cnt_of(input int ch);
        return xfer_count[ch*CNT_W +: CNT_W];
    endfunction

    task automatic model_step();
        exp_t e;
        logic found;
        logic v, r, evd, edc, eto;
        logic [DATA_W-1:0] dd;
        if (!RESETN || clear) begin
            for (int c = 0; c < N_CH; c++) begin
                m_pend[c] = 1'b0; m_hold[c] = '0; m_stall[c] = 0; m_cnt[c] = 0;
            end
            m_vd = '0; m_dc = '0; m_to = '0;
            m_fv = 1'b0; m_fch = '0; m_fcode = 2'd0;
        end else begin
            found = m_fv;
            for (int c = 0; c < N_CH; c++) begin
                v = valid[c]; r = ready[c]; dd = data[c*DATA_W +: DATA_W];
                evd = 1'b0; edc = 1'b0; eto = 1'b0;
                if (!m_pend[c]) begin
                    if (v && r) begin
                        if (m_cnt[c] < CNT_SAT) m_cnt[c]++;
                    end else if (v) begin
                        m_pend[c] = 1'b1; m_hold[c] = dd; m_stall[c] = 1;
                        eto = (STALL_LIMIT == 1);
                    end
                end else if (!v) begin
                    evd = 1'b1; m_pend[c] = 1'b0;
                end else begin
                    edc = (dd != m_hold[c]);
                    if (r) begin
                        if (m_cnt[c] < CNT_SAT) m_cnt[c]++;
                        m_pend[c] = 1'b0;
                    end else if (m_stall[c] < STALL_LIMIT) begin
                        m_stall[c]++;
                        eto = (m_stall[c] == STALL_LIMIT);
                    end
                end
                m_vd[c] = m_vd[c] | evd;
                m_dc[c] = m_dc[c] | edc;
                m_to[c] = m_to[c] | eto;
                if (!found && (evd || edc || eto)) begin
                    found = 1'b1; m_fv = 1'b1; m_fch = CH_W'(c);
                    m_fcode = evd ? 2'd1 : (edc ? 2'd2 : 2'd3);
                end
            end
        end
        for (int c = 0; c < N_CH; c++) e.cnt[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
        e.vd = m_vd; e.dc = m_dc; e.to = m_to;
        e.any = |{m_vd, m_dc, m_to};
        e.fv = m_fv; e.fch = m_fch; e.fcode = m_fcode;
        sb_q.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 64'd0, 64'd1);
            return;
        end
        e = sb_q.pop_front();
        chk("xfer_count", 64'(xfer_count), 64'(e.cnt));
        chk("err_valid_drop", 64'(err_valid_drop), 64'(e.vd));
        chk("err_data_change", 64'(err_data_change), 64'(e.dc));
        chk("err_timeout", 64'(err_timeout), 64'(e.to));
        chk("err_any", 64'(err_any), 64'(e.any));
        chk("first_err_valid", 64'(first_err_valid), 64'(e.fv));
        chk("first_err_chan", 64'(first_err_chan), 64'(e.fch));
        chk("first_err_code", 64'(first_err_code), 64'(e.fcode));
    endtask

    task automatic cyc(input logic rn, input logic cl, input logic [N_CH-1:0] v, r,
                       input logic [N_CH*DATA_W-1:0] d);
        @(negedge CLK);
        RESETN = rn; clear = cl; valid = v; ready = r; data = d;
        model_step();
        @(posedge CLK);
        #1;
        compare_out();
    endtask

    task automatic go(input logic [N_CH-1:0] v, r, input logic [N_CH*DATA_W-1:0] d);
        cyc(1'b1, 1'b0, v, r, d);
    endtask

    task automatic do_clear();
        cyc(1'b1, 1'b1, 3'b111, 3'b000, pk(5'h1F, 5'h1F, 5'h1F));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RESETN = 1'b0; clear = 1'b0; valid = '0; ready = '0; data = '0;

        cyc(1'b0, 1'b0, 3'b000, 3'b000, '0);
        cyc(1'b0, 1'b0, 3'b111, 3'b011, pk(1, 2, 3));
        chk("rst_count", 64'(xfer_count), 64'd0);
        chk("rst_any", 64'(err_any), 64'd0);
        chk("rst_fv", 64'(first_err_valid), 64'd0);

        // Clean traffic on ch0, ch1 idle
        for (int i = 0; i < 10; i++) go(3'b001, 3'b001, pk(DATA_W'(i), 0, 0));
        chk("clean_cnt0", 64'(cnt_of(0)), 64'd10);
        chk("clean_cnt1", 64'(cnt_of(1)), 64'd0);
        chk("clean_any", 64'(err_any), 64'd0);

        // Valid drop on ch2
        for (int i = 0; i < 3; i++) go(3'b100, 3'b000, pk(0, 0, 5'h07));
        chk("drop_pre", 64'(err_valid_drop), 64'd0);
        go(3'b000, 3'b000, pk(0, 0, 5'h07));
        chk("drop_flag", 64'(err_valid_drop), 64'b100);
        chk("drop_chan", 64'(first_err_chan), 64'd2);
        chk("drop_code", 64'(first_err_code), 64'd1);
        chk("drop_cnt2", 64'(cnt_of(2)), 64'd0);
        do_clear();

        // Data change on ch1, accepted on the 4th cycle
        go(3'b010, 3'b000, pk(0, 5'h0A, 0));
        go(3'b010, 3'b000, pk(0, 5'h0B, 0));
        go(3'b010, 3'b000, pk(0, 5'h0B, 0));
        go(3'b010, 3'b010, pk(0, 5'h0B, 0));
        chk("dchg_flag", 64'(err_data_change), 64'b010);
        chk("dchg_cnt1", 64'(cnt_of(1)), 64'd1);
        chk("dchg_code", 64'(first_err_code), 64'd2);
        chk("dchg_to", 64'(err_timeout), 64'd0);
        do_clear();

        // Timeout on ch0: 10 stalled cycles then accept
        for (int i = 0; i < 3; i++) go(3'b001, 3'b000, pk(5'h03, 0, 0));
        chk("to_before", 64'(err_timeout), 64'd0);
        go(3'b001, 3'b000, pk(5'h03, 0, 0));
        chk("to_at4", 64'(err_timeout), 64'b001);
        for (int i = 0; i < 6; i++) go(3'b001, 3'b000, pk(5'h03, 0, 0));
        go(3'b001, 3'b001, pk(5'h03, 0, 0));
        chk("to_cnt0", 64'(cnt_of(0)), 64'd1);
        chk("to_code", 64'(first_err_code), 64'd3);
        chk("to_chan", 64'(first_err_chan), 64'd0);
        do_clear();

        // Simultaneous drops on ch1/ch2, then a later ch0 timeout
        go(3'b110, 3'b000, pk(0, 5'h03, 5'h04));
        go(3'b110, 3'b000, pk(0, 5'h03, 5'h04));
        go(3'b000, 3'b000, pk(0, 0, 0));
        chk("sim_chan", 64'(first_err_chan), 64'd1);
        chk("sim_code", 64'(first_err_code), 64'd1);
        chk("sim_flags", 64'(err_valid_drop), 64'b110);
        for (int i = 0; i < 4; i++) go(3'b001, 3'b000, pk(5'h09, 0, 0));
        go(3'b001, 3'b001, pk(5'h09, 0, 0));
        chk("sim_to0", 64'(err_timeout), 64'b001);
        chk("sim_chan_frozen", 64'(first_err_chan), 64'd1);
        chk("sim_code_frozen", 64'(first_err_code), 64'd1);
        do_clear();

        // Counter saturation then clear
        for (int i = 0; i < 20; i++) go(3'b111, 3'b111, pk(DATA_W'(i), DATA_W'(i + 1), DATA_W'(i + 2)));
        chk("sat_cnt0", 64'(cnt_of(0)), 64'd15);
        chk("sat_cnt2", 64'(cnt_of(2)), 64'd15);
        do_clear();
        chk("clr_count", 64'(xfer_count), 64'd0);
        chk("clr_any", 64'(err_any), 64'd0);

        // Reset in the middle of a stall discards the episode
        go(3'b001, 3'b000, pk(5'h05, 0, 0));
        go(3'b001, 3'b000, pk(5'h05, 0, 0));
        cyc(1'b0, 1'b0, 3'b001, 3'b000, pk(5'h06, 0, 0));
        go(3'b000, 3'b000, pk(0, 0, 0));
        go(3'b000, 3'b000, pk(0, 0, 0));
        chk("rstmid_any", 64'(err_any), 64'd0);
        chk("rstmid_fv", 64'(first_err_valid), 64'd0);

        // Random traffic with narrow data range to provoke every error type
        for (int i = 0; i < 60; i++) begin
            go(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               pk(DATA_W'($urandom_range(0, 1)), DATA_W'($urandom_range(0, 1)),
                  DATA_W'($urandom_range(0, 1))));
            if (i == 30) do_clear();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hs_protocol_monitor.md
Name: hs_protocol_monitor

Overview:
- Parametrised ready/valid protocol monitor for N independent channels.
- Bound alongside an RTL block, like the existing per-module monitors, but adds registered state:
  - per-channel transfer counters;
  - stall-timeout detection;
  - valid-drop and data-stability checking;
  - sticky error flags;
  - capture of the first error.
- Passive: it never drives the monitored handshakes.

Parameters:
- N_CH, 3, number of monitored ready/valid channels (1..16)
- DATA_W, 5, payload width per channel
- CNT_W, 16, transfer-counter width per channel
- STALL_LIMIT, 64, consecutive stalled cycles (valid=1, ready=0) that raise a timeout (>=1)

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RESETN  input  1  synchronous active-low reset
- clear  input  1  synchronous soft clear; same effect as reset
- valid  input  N_CH  valid of each channel
- ready  input  N_CH  ready of each channel
- data  input  N_CH*DATA_W  payloads; channel i at [i*DATA_W +: DATA_W]
- xfer_count  output  N_CH*CNT_W  saturating transfer count per channel
- err_valid_drop  output  N_CH  sticky: valid withdrawn before acceptance
- err_data_change  output  N_CH  sticky: payload changed while stalled
- err_timeout  output  N_CH  sticky: stall reached STALL_LIMIT
- err_any  output  1  OR of all sticky flags
- first_err_valid  output  1  a first error has been captured
- first_err_chan  output  $clog2(N_CH) (min 1)  channel of first error
- first_err_code  output  2  1=valid_drop, 2=data_change, 3=timeout, 0=none

Behaviour:
- Reset/clear (RESETN=0 or clear=1, sampled at the edge):
  - all channels go to IDLE; all counters, flags and first_err_* go to 0; err_any=0.
  - Inputs in that cycle are ignored.
- Reset mid-stall: the episode is discarded; no error raised.
- Per-channel FSM, states IDLE and PEND:
  - IDLE, valid&ready: transfer; count+1; stay IDLE.
  - IDLE, valid&!ready: go PEND; latch data into hold register; stall_cnt=1.
  - IDLE, !valid: stay.
  - PEND, valid&ready: transfer; count+1; go IDLE. Compare data with hold first: a mismatch on the accepting cycle still raises data_change.
  - PEND, valid&!ready: stay PEND; compare data with hold; stall_cnt increments, saturating at STALL_LIMIT.
  - PEND, !valid: raise valid_drop; go IDLE (regardless of ready).
- Timeout: raised on the edge where stall_cnt transitions to STALL_LIMIT. With STALL_LIMIT=1 it is raised on the IDLE->PEND edge. Raised at most once per PEND episode.
- Data check: hold register is not updated within an episode. Every mismatching cycle re-asserts the (already sticky) flag.
- Counters: saturate at 2^CNT_W-1; no wrap.
- Flags: set on the edge after the offending sample (1-cycle latency) and hold until reset/clear. err_any is combinational OR of the registered flags.
- First-error capture: loads only when first_err_valid=0; then frozen until reset/clear.
  - Same edge, several channels: lowest channel index wins.
  - Same channel, same edge: priority valid_drop > data_change > timeout.
- X/Z on valid or ready is not checked; out of scope.

Decomposition:
- Package hs_mon_pkg:
  - err_code_t enum (NONE=0, VALID_DROP=1, DATA_CHANGE=2, TIMEOUT=3);
  - ch_state_t enum (IDLE, PEND);
  - helper function sat_inc.
- One sub-module, hs_channel_checker, instantiated N_CH times via generate:
  - holds FSM, hold register, stall counter and transfer counter;
  - emits per-channel error pulses and the 3 sticky flags.
- Top level: first-error priority encoder, err_any reduction, output packing.

Test Plan:
- Clean traffic: ch0 valid=ready=1 for 10 cycles; ch1 idle -> xfer_count[0]=10, xfer_count[1]=0, err_any=0.
- Valid drop: ch2 valid=1, ready=0 for 3 cycles, then valid=0 -> err_valid_drop[2]=1 one cycle later; first_err_chan=2, first_err_code=1; count unchanged.
- Data change: ch1 stalled with data=5'h0A, changed to 5'h0B on stall cycle 2, accepted on cycle 4 -> err_data_change[1]=1; xfer_count[1]=1; code=2.
- Timeout with STALL_LIMIT=4: ch0 stalled 10 cycles then accepted -> err_timeout[0] sets on the 4th stalled edge, once; xfer_count[0]=1.
- Simultaneous errors: ch1 and ch2 both drop valid on the same edge -> first_err_chan=1, code=1; a later ch0 timeout leaves first_err_* unchanged.
- Saturation/clear: CNT_W=4, 20 transfers -> count=15; then clear=1 for one cycle -> all outputs 0. Same check with RESETN=0 during a PEND episode -> no error after release.
